// File: rtl/rob_alloc_ctrl.sv
// Reorder-buffer allocation/retirement controller: owns head/tail pointers and
// per-entry completion flags, feeds dispatch (full/empty/entrynum) and commit.
module rob_alloc_ctrl #(
  parameter int DEPTH = 8,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             arst_i,
  input  logic             alloc_valid_i,
  input  logic             alloc_complete_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [7:0]       entrynum_o,
  input  logic             wb_valid_i,
  input  logic [7:0]       wb_entry_i,
  input  logic             commit_ready_i,
  output logic             commit_valid_o,
  output logic [7:0]       commit_entry_o,
  input  logic             flush_i,
  output logic [IDX_W:0]   count_o
);

  localparam logic [IDX_W:0] PTR_ONE = (IDX_W + 1)'(1);

  logic [IDX_W:0]     head_q, head_d;
  logic [IDX_W:0]     tail_q, tail_d;
  logic [DEPTH-1:0]   done_q, done_d;

  logic [IDX_W-1:0]   head_idx, tail_idx, wb_idx, wb_off;
  logic [IDX_W:0]     count;
  logic               full_raw, empty;
  logic               alloc_fire, wb_fire, commit_fire, commit_valid;
  logic [7-IDX_W:0]   unused_wb_hi;

  assign head_idx     = head_q[IDX_W-1:0];
  assign tail_idx     = tail_q[IDX_W-1:0];
  assign wb_idx       = wb_entry_i[IDX_W-1:0];
  assign unused_wb_hi = wb_entry_i[7:IDX_W];

  assign count    = tail_q - head_q;
  assign empty    = (head_q == tail_q);
  assign full_raw = (head_idx == tail_idx) && (head_q[IDX_W] != tail_q[IDX_W]);

  // Distance from head, modulo DEPTH, tells whether the written entry is live.
  assign wb_off = wb_idx - head_idx;

  assign commit_valid = !empty && done_q[head_idx];
  assign alloc_fire   = alloc_valid_i && !full_raw && !flush_i;
  assign wb_fire      = wb_valid_i && !flush_i && ({1'b0, wb_off} < count);
  assign commit_fire  = commit_valid && commit_ready_i && !flush_i;

  // Writeback is applied before the commit clear so a redundant writeback to a
  // retiring head cannot resurrect its done flag.
  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    done_d = done_q;
    if (flush_i) begin
      head_d = '0;
      tail_d = '0;
      done_d = '0;
    end else begin
      if (wb_fire) begin
        done_d[wb_idx] = 1'b1;
      end
      if (commit_fire) begin
        done_d[head_idx] = 1'b0;
        head_d           = head_q + PTR_ONE;
      end
      if (alloc_fire) begin
        done_d[tail_idx] = alloc_complete_i;
        tail_d           = tail_q + PTR_ONE;
      end
    end
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      head_q <= '0;
      tail_q <= '0;
      done_q <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      done_q <= done_d;
    end
  end

  assign full_o         = full_raw || flush_i;
  assign empty_o        = empty;
  assign entrynum_o     = 8'(tail_idx);
  assign commit_valid_o = commit_valid;
  assign commit_entry_o = 8'(head_idx);
  assign count_o        = count;

endmodule
